// File: rtl/sun_pll_fcnt_if.sv
// Control and result signals of the PLL frequency counter / lock detector.
// The driver of EN/REF/TARGET/TOL takes master; the counter takes slave.
interface sun_pll_fcnt_if #(
   parameter int WIDTH = 12
);
   logic             EN;
   logic             REF;
   logic [WIDTH-1:0] TARGET;
   logic [WIDTH-1:0] TOL;
   logic [WIDTH-1:0] CNT;
   logic             VALID;
   logic             UP;
   logic             DN;
   logic             LOCK;

   modport master (output EN, REF, TARGET, TOL, input CNT, VALID, UP, DN, LOCK);
   modport slave  (input EN, REF, TARGET, TOL, output CNT, VALID, UP, DN, LOCK);
endinterface

// File: rtl/sun_pll_fcnt.sv
// Counts CK cycles between REF rising edges and steers the VDD_ROSC loop.
// The first REF edge after enabling only arms the counter; every later edge reports.
module sun_pll_fcnt #(
   parameter int WIDTH = 12,
   parameter int LOCKN = 4
) (
   input  logic          CK,
   input  logic          RSTN,
   sun_pll_fcnt_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam logic [WIDTH-1:0] MAX     = '1;
   localparam logic [WIDTH:0]   MAX_EXT = {1'b0, MAX};
   localparam logic [4:0]       LOCKN_V = 5'(LOCKN);

   state_t           state, state_nxt;
   logic             s1, s2, s3;
   logic             evt;
   logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
   logic [3:0]       run, run_nxt;
   logic [4:0]       run_inc;
   logic [WIDTH-1:0] cnt_o, cnt_o_nxt;
   logic             valid, valid_nxt;
   logic             up, up_nxt;
   logic             dn, dn_nxt;
   logic             lock, lock_nxt;
   logic [WIDTH:0]   lo, hi, sum, m_ext;
   logic             sat, up_c, dn_c, in_win;

   // REF is asynchronous; only s2/s3 are trusted for edge detection
   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.REF;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign evt     = s2 & ~s3;
   assign cnt_inc = (cnt == MAX) ? MAX : cnt + 1'b1;

   // Window bounds at WIDTH+1 bits, clamped instead of wrapping
   assign sum    = {1'b0, bus.TARGET} + {1'b0, bus.TOL};
   assign lo     = (bus.TARGET >= bus.TOL) ? {1'b0, bus.TARGET - bus.TOL} : '0;
   assign hi     = (sum > MAX_EXT) ? MAX_EXT : sum;
   assign m_ext  = {1'b0, cnt_inc};
   assign sat    = (cnt_inc == MAX);
   assign up_c   = (m_ext < lo) & ~sat;
   assign dn_c   = (m_ext > hi) | sat;
   assign in_win = ~up_c & ~dn_c;
   assign run_inc = {1'b0, run} + 5'd1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      run_nxt   = run;
      cnt_o_nxt = cnt_o;
      valid_nxt = 1'b0;
      up_nxt    = up;
      dn_nxt    = dn;
      lock_nxt  = lock;
      if (!bus.EN || state == IDLE) begin
         state_nxt = bus.EN ? ARM : IDLE;
         cnt_nxt   = '0;
         run_nxt   = '0;
         cnt_o_nxt = '0;
         up_nxt    = 1'b0;
         dn_nxt    = 1'b0;
         lock_nxt  = 1'b0;
      end else begin
         case (state)
            ARM: begin
               if (evt) begin
                  cnt_nxt   = '0;
                  state_nxt = MEAS;
               end
            end
            MEAS: begin
               if (evt) begin
                  cnt_o_nxt = cnt_inc;
                  valid_nxt = 1'b1;
                  cnt_nxt   = '0;
                  up_nxt    = up_c;
                  dn_nxt    = dn_c;
                  if (in_win) begin
                     run_nxt  = (run_inc > LOCKN_V) ? LOCKN_V[3:0] : run_inc[3:0];
                     lock_nxt = (run_inc >= LOCKN_V);
                  end else begin
                     run_nxt  = '0;
                     lock_nxt = 1'b0;
                  end
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
         cnt   <= '0;
         run   <= '0;
         cnt_o <= '0;
         valid <= 1'b0;
         up    <= 1'b0;
         dn    <= 1'b0;
         lock  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         run   <= run_nxt;
         cnt_o <= cnt_o_nxt;
         valid <= valid_nxt;
         up    <= up_nxt;
         dn    <= dn_nxt;
         lock  <= lock_nxt;
      end
   end

   assign bus.CNT   = cnt_o;
   assign bus.VALID = valid;
   assign bus.UP    = up;
   assign bus.DN    = dn;
   assign bus.LOCK  = lock;
endmodule

// File: tb/tb_sun_pll_fcnt.sv
// Bench for sun_pll_fcnt: REF periods from a table, expected results queued at
// each REF edge and matched against every VALID pulse.
module tb_sun_pll_fcnt;
   localparam int W = 12;

   typedef struct {
      int           p;
      logic [W-1:0] target;
      logic [W-1:0] tol;
      logic         up;
      logic         dn;
      logic         lock;
   } vec_t;

   typedef struct {
      logic [W-1:0] cnt;
      logic         up;
      logic         dn;
      logic         lock;
   } exp_t;

   logic CK   = 1'b0;
   logic RSTN = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t tbl[17];

   sun_pll_fcnt_if #(.WIDTH(W)) bus();
   sun_pll_fcnt #(.WIDTH(W), .LOCKN(4)) dut (.CK(CK), .RSTN(RSTN), .bus(bus));

   always #5 CK = ~CK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic void push(input int p, input logic u, input logic d, input logic l);
      exp_t e;
      e.cnt  = (p > 4095) ? 12'hFFF : 12'(p);
      e.up   = u;
      e.dn   = d;
      e.lock = l;
      sb.push_back(e);
   endfunction

   // One REF period of p CK cycles ending in a rising edge; window inputs change mid-period
   task automatic ref_period(input int p, input logic [W-1:0] tg, input logic [W-1:0] tl);
      repeat (2) @(posedge CK);
      #2 bus.REF = 1'b0;
      repeat (3) @(posedge CK);
      #2 begin
         bus.TARGET = tg;
         bus.TOL    = tl;
      end
      repeat (p - 5) @(posedge CK);
      #2 bus.REF = 1'b1;
   endtask

   task automatic ref_rise_in(input int n);
      repeat (n) @(posedge CK);
      #2 bus.REF = 1'b1;
   endtask

   always @(negedge CK) begin
      if (bus.VALID === 1'b1) begin
         chk("valid_expected", 32'(sb.size() != 0), 32'd1);
         chk("up_dn_excl", 32'(bus.UP & bus.DN), 32'd0);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("cnt", 32'(bus.CNT), 32'(e.cnt));
            chk("up", 32'(bus.UP), 32'(e.up));
            chk("dn", 32'(bus.DN), 32'(e.dn));
            chk("lock", 32'(bus.LOCK), 32'(e.lock));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.EN     = 1'b0;
      bus.REF    = 1'b0;
      bus.TARGET = 12'd100;
      bus.TOL    = 12'd2;
      tbl[0]  = '{100,  12'd100,  12'd2,   1'b0, 1'b0, 1'b0};
      tbl[1]  = '{100,  12'd100,  12'd2,   1'b0, 1'b0, 1'b0};
      tbl[2]  = '{101,  12'd100,  12'd2,   1'b0, 1'b0, 1'b0};
      tbl[3]  = '{99,   12'd100,  12'd2,   1'b0, 1'b0, 1'b1};
      tbl[4]  = '{100,  12'd100,  12'd2,   1'b0, 1'b0, 1'b1};
      tbl[5]  = '{90,   12'd100,  12'd2,   1'b1, 1'b0, 1'b0};
      tbl[6]  = '{110,  12'd100,  12'd2,   1'b0, 1'b1, 1'b0};
      tbl[7]  = '{98,   12'd100,  12'd2,   1'b0, 1'b0, 1'b0};
      tbl[8]  = '{102,  12'd100,  12'd2,   1'b0, 1'b0, 1'b0};
      tbl[9]  = '{97,   12'd100,  12'd2,   1'b1, 1'b0, 1'b0};
      tbl[10] = '{103,  12'd100,  12'd2,   1'b0, 1'b1, 1'b0};
      tbl[11] = '{100,  12'd100,  12'd2,   1'b0, 1'b0, 1'b0};
      tbl[12] = '{250,  12'd100,  12'd150, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{200,  12'd100,  12'd150, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{30,   12'd100,  12'd150, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{251,  12'd100,  12'd150, 1'b0, 1'b1, 1'b0};
      tbl[16] = '{4000, 12'd4000, 12'd200, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge CK);
      @(negedge CK);
      chk("rst_cnt", 32'(bus.CNT), 32'd0);
      chk("rst_valid", 32'(bus.VALID), 32'd0);
      chk("rst_up", 32'(bus.UP), 32'd0);
      chk("rst_dn", 32'(bus.DN), 32'd0);
      chk("rst_lock", 32'(bus.LOCK), 32'd0);
      @(posedge CK);
      #2 RSTN = 1'b1;
      repeat (2) @(posedge CK);
      #2 bus.EN = 1'b1;

      // Arming edge: must not produce VALID
      ref_rise_in(3);
      foreach (tbl[i]) begin
         ref_period(tbl[i].p, tbl[i].target, tbl[i].tol);
         push(tbl[i].p, tbl[i].up, tbl[i].dn, tbl[i].lock);
      end

      // Saturation: 5000 CK without an edge
      ref_period(5000, 12'd100, 12'd2);
      push(5000, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         ref_period(100, 12'd100, 12'd2);
         push(100, 1'b0, 1'b0, k == 3);
      end

      // EN dropped mid-measurement
      repeat (50) @(posedge CK);
      @(negedge CK);
      chk("lock_before_drop", 32'(bus.LOCK), 32'd1);
      @(posedge CK);
      #2 bus.EN = 1'b0;
      @(posedge CK);
      @(negedge CK);
      chk("drop_cnt", 32'(bus.CNT), 32'd0);
      chk("drop_up", 32'(bus.UP), 32'd0);
      chk("drop_dn", 32'(bus.DN), 32'd0);
      chk("drop_lock", 32'(bus.LOCK), 32'd0);
      ref_period(100, 12'd100, 12'd2);
      ref_period(100, 12'd100, 12'd2);

      // Re-enable: first edge arms, second reports
      repeat (10) @(posedge CK);
      #2 bus.EN = 1'b1;
      ref_period(90, 12'd100, 12'd2);
      ref_period(100, 12'd100, 12'd2);
      push(100, 1'b0, 1'b0, 1'b0);

      // REF edge detected in the same cycle EN falls
      repeat (2) @(posedge CK);
      #2 bus.REF = 1'b0;
      repeat (98) @(posedge CK);
      #2 bus.REF = 1'b1;
      repeat (2) @(posedge CK);
      #2 bus.EN = 1'b0;
      @(posedge CK);
      @(negedge CK);
      chk("en_fall_valid", 32'(bus.VALID), 32'd0);
      chk("en_fall_cnt", 32'(bus.CNT), 32'd0);

      // Reset while locked
      repeat (10) @(posedge CK);
      #2 bus.EN = 1'b1;
      ref_period(100, 12'd100, 12'd2);
      for (int k = 0; k < 4; k++) begin
         ref_period(100, 12'd100, 12'd2);
         push(100, 1'b0, 1'b0, k == 3);
      end
      repeat (40) @(posedge CK);
      @(negedge CK);
      chk("lock_before_rst", 32'(bus.LOCK), 32'd1);
      #1 RSTN = 1'b0;
      #1;
      chk("arst_cnt", 32'(bus.CNT), 32'd0);
      chk("arst_valid", 32'(bus.VALID), 32'd0);
      chk("arst_up", 32'(bus.UP), 32'd0);
      chk("arst_dn", 32'(bus.DN), 32'd0);
      chk("arst_lock", 32'(bus.LOCK), 32'd0);
      bus.REF = 1'b0;
      repeat (3) @(posedge CK);
      #2 RSTN = 1'b1;
      ref_rise_in(3);
      for (int k = 0; k < 4; k++) begin
         ref_period(100, 12'd100, 12'd2);
         push(100, 1'b0, 1'b0, k == 3);
      end

      repeat (10) @(posedge CK);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
